// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, 4/COLS_PER_CYCLE+1 cycles to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so upstream must hold in_valid.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] prevState,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] nextState,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step wraps to 0 for COLS_PER_CYCLE=4, leaving the counter parked at 0.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_work;
    logic [127:0]   w_work_calc;
    logic [1:0]     r_cnt;
    logic           w_accept;
    logic           w_last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h9:    res = x8 ^ a;
            4'hB:    res = x8 ^ x2 ^ a;
            4'hD:    res = x8 ^ x4 ^ a;
            default: res = x8 ^ x4 ^ x2;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD),
                gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB),
                gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE)};
    endfunction

    // Row-major layout: byte s[r][c] sits at index 4r+c counted from the MSB.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] col;
        col = '0;
        for (int r = 0; r < 4; r++) begin
            col[31-8*r -: 8] = s[127-8*(4*r+int'(c)) -: 8];
        end
        return col;
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] col);
        logic [127:0] res;
        res = s;
        for (int r = 0; r < 4; r++) begin
            res[127-8*(4*r+int'(c)) -: 8] = col[31-8*r -: 8];
        end
        return res;
    endfunction

    always_comb begin
        w_work_calc = r_work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_work_calc = set_col(w_work_calc, r_cnt + 2'(g),
                                  inv_col(get_col(r_work, r_cnt + 2'(g))));
        end
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        nextState   = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                nextState = r_work;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= prevState;
            r_cnt  <= '0;
        end else if (r_state == CALC) begin
            r_work <= w_work_calc;
            r_cnt  <= r_cnt + CNT_STEP;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle), one driven at a time.
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] exp;
        int           acc;
        int           lat;
    } sb_t;

    logic         reset_n;
    logic         in_valid;
    logic [127:0] prev_state;
    logic         out_ready = 1'b1;
    logic         ready_val = 1'b1;
    bit           stall_mode = 1'b0;
    logic [1:0]   sel;
    logic [2:0]   iv, ir, ov, orr, bsy;
    logic [127:0] ns0, ns1, ns2;
    logic         ir_m, ov_m, bsy_m;
    logic [127:0] ns_m;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    sb_t          q[$];
    int           lat_tab[3] = '{5, 3, 2};

    for (genvar k = 0; k < 3; k++) begin : g_ctl
        assign iv[k]  = in_valid && (sel == 2'(k));
        assign orr[k] = (sel == 2'(k)) ? out_ready : 1'b1;
    end

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]), .prevState(prev_state),
        .out_valid(ov[0]), .out_ready(orr[0]), .nextState(ns0), .busy(bsy[0]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]), .prevState(prev_state),
        .out_valid(ov[1]), .out_ready(orr[1]), .nextState(ns1), .busy(bsy[1]));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]), .prevState(prev_state),
        .out_valid(ov[2]), .out_ready(orr[2]), .nextState(ns2), .busy(bsy[2]));

    assign ir_m  = ir[sel];
    assign ov_m  = ov[sel];
    assign bsy_m = bsy[sel];
    always_comb begin
        case (sel)
            2'd1:    ns_m = ns1;
            2'd2:    ns_m = ns2;
            default: ns_m = ns0;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : ready_val;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input int c, input logic [31:0] col);
        logic [127:0] r;
        r = s;
        for (int i = 0; i < 4; i++) r[127-8*(4*i+c) -: 8] = col[31-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] fill(input logic [31:0] col);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r = put_col(r, c, col);
        return r;
    endfunction

    // Forward MixColumns used only to build round-trip stimulus.
    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*c -: 8];
            a1 = s[127-8*(4+c) -: 8];
            a2 = s[127-8*(8+c) -: 8];
            a3 = s[127-8*(12+c) -: 8];
            r = put_col(r, c, {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)});
        end
        return r;
    endfunction

    task automatic issue(input logic [127:0] d, input logic [127:0] e, input int lat,
                         input bit push, output int acc);
        sb_t ent;
        bit  ok;
        ok = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        prev_state = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ir_m) ok = 1'b1;
        end
        if (ok) begin
            acc = cyc;
            if (push) begin
                ent.exp = e;
                ent.acc = cyc;
                ent.lat = lat;
                q.push_back(ent);
            end
        end else begin
            chk("accept_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", 128'(q.size()), 0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold-stability while stalled.
    int           fv_cyc = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b1;
    logic [127:0] pd = '0;
    always @(negedge clk) begin
        sb_t e;
        if (ov_m && !pv) fv_cyc = cyc;
        if (pv && !pr && reset_n) begin
            chk("hold_valid", 128'(ov_m), 1);
            chk("hold_data", ns_m, pd);
        end
        if (ov_m && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", ns_m, 0);
            end else begin
                e = q.pop_front();
                chk("result", ns_m, e.exp);
                if (e.lat > 0) chk("latency", 128'(fv_cyc - e.acc), 128'(e.lat));
            end
        end
        pv = ov_m;
        pr = out_ready;
        pd = ns_m;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v1_in, v1_out, v2_in, v2_out, orig, a, b;
        int acc1, acc2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        prev_state = '0;
        sel = 2'd0;

        v1_in  = put_col('0, 0, 32'h8e4da1bc);
        v1_out = put_col('0, 0, 32'hdb135345);
        v2_in  = put_col(put_col(put_col(put_col('0, 0, 32'h8e4da1bc), 1, 32'hd5d5d7d6),
                                 2, 32'h9fdc589d), 3, 32'h4d7ebdf8);
        v2_out = put_col(put_col(put_col(put_col('0, 0, 32'hdb135345), 1, 32'hd4d4d4d5),
                                 2, 32'hf20a225c), 3, 32'h2d26314c);

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("reset_out_valid", 128'(ov_m), 0);
            chk("reset_busy", 128'(bsy_m), 0);
            chk("reset_next_state", ns_m, 0);
        end
        sel = 2'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 128'(ir_m), 1);
        @(posedge clk);
        #1;

        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            issue(v1_in, v1_out, lat_tab[s], 1'b1, acc1);
            issue(fill(32'h01010101), fill(32'h01010101), lat_tab[s], 1'b1, acc1);
            issue(fill(32'hc6c6c6c6), fill(32'hc6c6c6c6), lat_tab[s], 1'b1, acc1);
            issue(v2_in, v2_out, lat_tab[s], 1'b1, acc1);
            drain();
        end

        sel = 2'd0;
        issue(v1_in, v1_out, 5, 1'b1, acc1);
        issue(v2_in, v2_out, 5, 1'b1, acc2);
        chk("back_to_back_spacing", 128'(acc2 - acc1), 6);
        drain();

        // Backpressure: hold the first result, keep offering a second input.
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        issue(v2_in, v2_out, 5, 1'b1, acc1);
        for (int i = 0; i < 50 && !ov_m; i++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        prev_state = v1_in;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 128'(ov_m), 1);
            chk("stall_in_ready", 128'(ir_m), 0);
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(negedge clk);
        chk("consume_no_accept", 128'(ir_m), 0);
        @(negedge clk);
        chk("idle_after_consume", 128'(ir_m), 1);
        begin
            sb_t ent;
            ent.exp = v1_out;
            ent.acc = cyc;
            ent.lat = 5;
            q.push_back(ent);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset during the second CALC cycle.
        issue(v2_in, v2_out, 5, 1'b0, acc1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("calc_busy", 128'(bsy_m), 1);
        @(negedge clk);
        chk("midreset_out_valid", 128'(ov_m), 0);
        chk("midreset_next_state", ns_m, 0);
        chk("midreset_busy", 128'(bsy_m), 0);
        chk("midreset_idle", 128'(ir_m), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(v2_in, v2_out, 5, 1'b1, acc1);
        drain();

        // Round trip with random output stalls.
        stall_mode = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int n = 0; n < ((s == 0) ? 1000 : 100); n++) begin
                orig = {$urandom, $urandom, $urandom, $urandom};
                a = mix(orig);
                issue(a, orig, lat_tab[s], 1'b1, acc1);
            end
            drain();
        end
        stall_mode = 1'b0;
        b = '0;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
